// File: rtl/result_bcd_converter.sv
// result_bcd_converter: converts a signed ALU result magnitude to packed BCD with double-dabble
// Ports: clk/reset (sync, active-high); in_valid/in_ready/in_value/in_neg upstream handshake;
//        out_valid/out_ready/out_bcd/out_neg downstream handshake; busy high in SHIFT and DONE.
// Optional feature: define LZ_BLANK_EN to replace leading-zero digits above digit 0 with 4'hF.
module result_bcd_converter #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_value,
  input  logic                  in_neg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_next;
  logic [CNT_W-1:0] count;
  logic [DATA_W-1:0] shreg;
  logic [4*DIGITS-1:0] acc, adj, acc_next, bcd_fmt;
  logic neg_r, last;
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = acc[4*i+:4] + ((acc[4*i+:4] >= 4'd5) ? 4'd3 : 4'd0);
    // the shift discards the top bit of the adjusted accumulator, which is always zero when no overflow occurs
    acc_next = (adj << 1) | {{(4*DIGITS-1){1'b0}}, shreg[DATA_W-1]};
    last = count == CNT_W'(DATA_W-1);
  end
`ifdef LZ_BLANK_EN
  logic lead;
  always_comb begin
    bcd_fmt = acc_next;
    lead = 1'b1;
    for (int i = DIGITS-1; i > 0; i--) begin
      lead = lead & (acc_next[4*i+:4] == 4'd0);
      if (lead) bcd_fmt[4*i+:4] = 4'hF;
    end
  end
`else
  assign bcd_fmt = acc_next;
`endif
  always_comb begin
    state_next = (state == IDLE && in_valid)  ? SHIFT :
                 (state == SHIFT && last)     ? DONE  :
                 (state == DONE && out_ready) ? IDLE  : state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
      acc <= '0;
      neg_r <= 1'b0;
      out_bcd <= '0;
      out_neg <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && in_valid) begin
        shreg <= in_value;
        acc <= '0;
        neg_r <= in_neg & (|in_value);
        count <= '0;
      end
      if (state == SHIFT) begin
        shreg <= shreg << 1;
        acc <= acc_next;
        count <= count + 1'b1;
        if (last) begin
          out_bcd <= bcd_fmt;
          out_neg <= neg_r;
        end
      end
    end
  end
endmodule

// File: tb/tb_result_bcd_converter.sv
// tb_result_bcd_converter: directed table-driven bench for result_bcd_converter
module tb_result_bcd_converter;
  logic clk = 0, reset = 1, in_valid = 0, in_neg = 0, out_ready = 1;
  logic in_ready, out_valid, out_neg, busy;
  logic [15:0] in_value = 0;
  logic [19:0] out_bcd;
  int checks = 0, failures = 0;
  typedef struct {logic [15:0] v; logic n; logic [19:0] b; logic bn;} vec_t;
  vec_t vecs[16];
  result_bcd_converter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .in_neg(in_neg), .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
    .out_neg(out_neg), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [19:0] fmt(input logic [19:0] b);
    fmt = b;
`ifdef LZ_BLANK_EN
    begin
      bit lead = 1;
      for (int i = 4; i > 0; i--) begin
        lead = lead && (b[4*i+:4] == 4'd0);
        if (lead) fmt[4*i+:4] = 4'hF;
      end
    end
`endif
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask
  task automatic send(input logic [15:0] v, input logic n);
    int lat;
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1);
    in_value = v;
    in_neg = n;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", lat, 17);
  endtask
  task automatic take(input string nm, input logic [19:0] b, input logic bn);
    chk({nm, "_bcd"}, out_bcd, fmt(b));
    chk({nm, "_neg"}, out_neg, bn);
    @(posedge clk);
    #1 chk({nm, "_done_one_cycle"}, {out_valid, in_ready, busy}, 3'b010);
  endtask
  initial begin
    logic [19:0] hb;
    logic hn;
    vecs = '{
      '{16'd0, 0, 20'h00000, 0}, '{16'd1, 1, 20'h00001, 1}, '{16'd9, 0, 20'h00009, 0},
      '{16'd10, 1, 20'h00010, 1}, '{16'd99, 0, 20'h00099, 0}, '{16'd100, 0, 20'h00100, 0},
      '{16'd999, 1, 20'h00999, 1}, '{16'd1000, 0, 20'h01000, 0}, '{16'd9999, 0, 20'h09999, 0},
      '{16'd10000, 1, 20'h10000, 1}, '{16'd12345, 1, 20'h12345, 1}, '{16'd32768, 0, 20'h32768, 0},
      '{16'd42, 0, 20'h00042, 0}, '{16'd0, 1, 20'h00000, 0}, '{16'd65534, 1, 20'h65534, 1},
      '{16'd65535, 0, 20'h65535, 0}
    };
    in_valid = 1;
    in_value = 16'd77;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", {in_ready, out_valid, out_bcd, out_neg, busy}, {1'b1, 1'b0, 20'h0, 1'b0, 1'b0});
    reset = 0;
    in_valid = 0;
    @(posedge clk);
    #1 chk("no_capture_during_reset", {in_ready, busy}, 2'b10);
    send(16'd0, 0);
    take("zero", 20'h00000, 0);
    send(16'hFFFF, 0);
    take("max", 20'h65535, 0);
    send(16'd12345, 1);
    take("neg12345", 20'h12345, 1);
    send(16'd0, 1);
    take("negzero", 20'h00000, 0);
    out_ready = 0;
    send(16'd9876, 1);
    hb = out_bcd;
    hn = out_neg;
    chk("hold_first_bcd", out_bcd, fmt(20'h09876));
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 4);
      in_value = 16'd5;
      in_neg = 0;
      @(posedge clk);
      #1 chk("hold_stable", {out_valid, in_ready, busy, out_bcd, out_neg}, {3'b101, hb, hn});
    end
    in_valid = 0;
    out_ready = 1;
    take("hold_release", 20'h09876, 1);
    @(negedge clk);
    chk("second_pulse_ignored", {in_ready, out_valid, busy}, 3'b100);
    @(negedge clk);
    in_value = 16'd255;
    in_neg = 1;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (7) @(posedge clk);
    #1 chk("mid_shift_busy", {busy, in_ready}, 2'b10);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    chk("abort_outputs", {in_ready, out_valid, out_bcd, out_neg, busy}, {1'b1, 1'b0, 20'h0, 1'b0, 1'b0});
    repeat (20) @(posedge clk);
    #1 chk("abort_never_presented", {out_valid, in_ready}, 2'b01);
    send(16'd42, 0);
    take("after_abort", 20'h00042, 0);
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].v, vecs[i].n);
      take($sformatf("stream%0d", i), vecs[i].b, vecs[i].bn);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
